// File: rtl/board_eval_if.sv
// Bus bundle for board_eval: the CPU register port (slave_*) and the SDRAM master port (master_*).
// Modport slave is board_eval's view; modport master is the CPU/SDRAM environment's view.
interface board_eval_if;
    logic        slave_waitrequest;
    logic [3:0]  slave_address;
    logic        slave_read;
    logic [31:0] slave_readdata;
    logic        slave_write;
    logic [31:0] slave_writedata;
    logic        master_waitrequest;
    logic [31:0] master_address;
    logic        master_read;
    logic [31:0] master_readdata;
    logic        master_readdatavalid;
    logic        master_write;
    logic [31:0] master_writedata;

    modport slave (
        input  slave_address, slave_read, slave_write, slave_writedata,
               master_waitrequest, master_readdata, master_readdatavalid,
        output slave_waitrequest, slave_readdata,
               master_address, master_read, master_write, master_writedata
    );

    modport master (
        output slave_address, slave_read, slave_write, slave_writedata,
               master_waitrequest, master_readdata, master_readdatavalid,
        input  slave_waitrequest, slave_readdata,
               master_address, master_read, master_write, master_writedata
    );
endinterface

// File: rtl/board_eval.sv
// Streams N child boards from SDRAM, writes a material score per board and tracks the best one.
// Define BOARD_EVAL_PST_EN to add the pawn-advancement bonus to each pawn's value.
module board_eval #(
    parameter int unsigned MAX_BOARDS = 32,
    parameter int          PAWN_VAL   = 100,
    parameter int          KNIGHT_VAL = 320,
    parameter int          BISHOP_VAL = 330,
    parameter int          ROOK_VAL   = 500,
    parameter int          QUEEN_VAL  = 900,
    parameter int          KING_VAL   = 20000
) (
    input logic         clk,
    input logic         rst,
    board_eval_if.slave bus
);
    localparam int unsigned BW = $clog2(MAX_BOARDS + 1);
    localparam logic [31:0] IDX_NONE = 32'hFFFF_FFFF;
    localparam logic signed [31:0] SCORE_MIN = 32'sh8000_0000;

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_RD_SQ, S_WT_SQ, S_WR_SCORE, S_UPD_BEST, S_DONE
    } state_t;

    state_t             state_r;
    logic [31:0]        src_base_r;
    logic [31:0]        score_base_r;
    logic [BW-1:0]      num_boards_r;
    logic               side_r;
    logic [BW-1:0]      board_r;
    logic [5:0]         sq_r;
    logic signed [31:0] acc_r;
    logic signed [31:0] best_score_r;
    logic [31:0]        best_idx_r;
    logic               master_read_r;
    logic               master_write_r;
    logic [31:0]        master_address_r;
    logic [31:0]        master_writedata_r;

    logic               busy_s;
    logic               rd_best_s;
    logic               start_s;
    logic               better_s;
    logic signed [31:0] sq_value_s;
    logic signed [31:0] acc_next_s;
    logic               unused_rd_hi;

    function automatic logic signed [31:0] piece_value(input logic [7:0] piece);
        logic [7:0]         mag;
        logic signed [31:0] val;
        mag = piece[7] ? (8'd0 - piece) : piece;
        case (mag)
            8'd1:    val = 32'(PAWN_VAL);
            8'd2:    val = 32'(KNIGHT_VAL);
            8'd3:    val = 32'(BISHOP_VAL);
            8'd4:    val = 32'(ROOK_VAL);
            8'd5:    val = 32'(QUEEN_VAL);
            8'd6:    val = 32'(KING_VAL);
            default: val = 32'sd0;
        endcase
        return piece[7] ? -val : val;
    endfunction

`ifdef BOARD_EVAL_PST_EN
    function automatic logic signed [31:0] pst_bonus(input logic [7:0] piece, input logic [2:0] row);
        logic signed [31:0] r;
        r = $signed({29'd0, row});
        if (piece == 8'h01) begin
            return 32'sd10 * (r - 32'sd1);
        end else if (piece == 8'hFF) begin
            return -(32'sd10 * (32'sd6 - r));
        end else begin
            return 32'sd0;
        end
    endfunction
`endif

    function automatic logic [31:0] sq_addr(input logic [31:0] base, input logic [BW-1:0] board,
                                            input logic [5:0] sq);
        return base + (32'(board) << 8) + (32'(sq) << 2);
    endfunction

    assign unused_rd_hi = ^bus.master_readdata[31:8];

    assign bus.master_read      = master_read_r;
    assign bus.master_write     = master_write_r;
    assign bus.master_address   = master_address_r;
    assign bus.master_writedata = master_writedata_r;

    // Square value, control decodes and the CPU read mux.
    always_comb begin
        sq_value_s = piece_value(bus.master_readdata[7:0]);
`ifdef BOARD_EVAL_PST_EN
        sq_value_s = sq_value_s + pst_bonus(bus.master_readdata[7:0], sq_r[5:3]);
`endif
        acc_next_s = acc_r + sq_value_s;
        busy_s     = (state_r != S_IDLE) && (state_r != S_DONE);
        rd_best_s  = bus.slave_read && (bus.slave_address == 4'd0);
        start_s    = bus.slave_write && (bus.slave_address == 4'd0) && !busy_s;
        // No best yet means the first board always wins, whichever side is to move.
        if (best_idx_r == IDX_NONE) begin
            better_s = 1'b1;
        end else if (side_r) begin
            better_s = acc_r < best_score_r;
        end else begin
            better_s = acc_r > best_score_r;
        end
        bus.slave_waitrequest = rd_best_s && busy_s;
        if (bus.slave_read) begin
            case (bus.slave_address)
                4'd0:    bus.slave_readdata = best_idx_r;
                4'd5:    bus.slave_readdata = best_score_r;
                4'd6:    bus.slave_readdata = 32'(board_r);
                default: bus.slave_readdata = 32'd0;
            endcase
        end else begin
            bus.slave_readdata = 32'd0;
        end
    end

    // Register file writes plus the evaluation state machine.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r            <= S_IDLE;
            src_base_r         <= 32'd0;
            score_base_r       <= 32'd0;
            num_boards_r       <= '0;
            side_r             <= 1'b0;
            board_r            <= '0;
            sq_r               <= 6'd0;
            acc_r              <= 32'sd0;
            best_score_r       <= SCORE_MIN;
            best_idx_r         <= IDX_NONE;
            master_read_r      <= 1'b0;
            master_write_r     <= 1'b0;
            master_address_r   <= 32'hFFFF_FFFF;
            master_writedata_r <= 32'hFFFF_FFFF;
        end else begin
            if (bus.slave_write) begin
                case (bus.slave_address)
                    4'd1: src_base_r   <= bus.slave_writedata;
                    4'd2: num_boards_r <= (bus.slave_writedata > 32'(MAX_BOARDS))
                                          ? BW'(MAX_BOARDS) : BW'(bus.slave_writedata);
                    4'd3: score_base_r <= bus.slave_writedata;
                    4'd4: side_r       <= bus.slave_writedata[0];
                    default: ;
                endcase
            end
            case (state_r)
                S_IDLE, S_DONE: begin
                    if (start_s) begin
                        board_r      <= '0;
                        sq_r         <= 6'd0;
                        acc_r        <= 32'sd0;
                        best_score_r <= SCORE_MIN;
                        best_idx_r   <= IDX_NONE;
                        state_r      <= S_INIT;
                    end else if (state_r == S_DONE && rd_best_s) begin
                        state_r <= S_IDLE;
                    end
                end
                S_INIT: begin
                    if (num_boards_r == '0) begin
                        state_r <= S_DONE;
                    end else begin
                        master_read_r    <= 1'b1;
                        master_address_r <= sq_addr(src_base_r, board_r, 6'd0);
                        state_r          <= S_RD_SQ;
                    end
                end
                S_RD_SQ: begin
                    if (!bus.master_waitrequest) begin
                        master_read_r <= 1'b0;
                        state_r       <= S_WT_SQ;
                    end
                end
                S_WT_SQ: begin
                    if (bus.master_readdatavalid) begin
                        acc_r <= acc_next_s;
                        if (sq_r == 6'd63) begin
                            master_write_r     <= 1'b1;
                            master_writedata_r <= acc_next_s;
                            master_address_r   <= score_base_r + (32'(board_r) << 2);
                            state_r            <= S_WR_SCORE;
                        end else begin
                            sq_r             <= sq_r + 6'd1;
                            master_read_r    <= 1'b1;
                            master_address_r <= sq_addr(src_base_r, board_r, sq_r + 6'd1);
                            state_r          <= S_RD_SQ;
                        end
                    end
                end
                S_WR_SCORE: begin
                    if (!bus.master_waitrequest) begin
                        master_write_r <= 1'b0;
                        state_r        <= S_UPD_BEST;
                    end
                end
                S_UPD_BEST: begin
                    if (better_s) begin
                        best_score_r <= acc_r;
                        best_idx_r   <= 32'(board_r);
                    end
                    board_r <= board_r + BW'(1);
                    if (board_r + BW'(1) == num_boards_r) begin
                        state_r <= S_DONE;
                    end else begin
                        acc_r            <= 32'sd0;
                        sq_r             <= 6'd0;
                        master_read_r    <= 1'b1;
                        master_address_r <= sq_addr(src_base_r, board_r + BW'(1), 6'd0);
                        state_r          <= S_RD_SQ;
                    end
                end
                default: state_r <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/board_eval.md
Name: board_eval

Overview:
- Downstream consumer of the per-piece move generators (pawn and siblings).
- After a generator writes N child boards back-to-back into SDRAM, the CPU points board_eval at that region.
- The block streams each 64-square board over its Avalon-MM master, computes a signed material score and writes one score word per board to a result array.
- It tracks the best board for the side to move, which the CPU reads back as the index of the chosen child.

Parameters:
MAX_BOARDS, 32, largest accepted board count; larger writes are clamped to this value
PAWN_VAL, 100, value of |piece|=1
KNIGHT_VAL, 320, value of |piece|=2
BISHOP_VAL, 330, value of |piece|=3
ROOK_VAL, 500, value of |piece|=4
QUEEN_VAL, 900, value of |piece|=5
KING_VAL, 20000, value of |piece|=6

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
slave_waitrequest  out  1  stalls CPU read of addr 0 while busy
slave_address  in  4  CPU register select
slave_read  in  1  CPU read strobe
slave_readdata  out  32  CPU read data
slave_write  in  1  CPU write strobe
slave_writedata  in  32  CPU write data
master_waitrequest  in  1  SDRAM stall
master_address  out  32  SDRAM byte address
master_read  out  1  SDRAM read request
master_readdata  in  32  SDRAM read data
master_readdatavalid  in  1  SDRAM read data valid
master_write  out  1  SDRAM write request
master_writedata  out  32  SDRAM write data

Behaviour:
- Interface: one clock, clk; reset rst is synchronous, active-high.
- Reset values:
  - state IDLE; all master/slave strobes 0; slave_waitrequest 0; slave_readdata 0.
  - master_address and master_writedata 0xFFFFFFFF.
  - best_idx 0xFFFFFFFF; best_score 0x80000000.
- Slave write map:
  - 1 = src_base.
  - 2 = num_boards, clamped to MAX_BOARDS.
  - 3 = score_base.
  - 4 = side: bit0 0 means white, maximise; 1 means black, minimise.
  - 0 = start: accepted in IDLE or DONE only; ignored while busy.
- Slave read map:
  - 0 = best_idx. slave_waitrequest is held high from the read until DONE, then the read completes and the block returns to IDLE.
  - 5 = best_score.
  - 6 = boards_done.
  - Others return 0.
- Piece encoding: master_readdata[7:0] is a signed piece.
  - Positive is white, negative is black, 0 is empty.
  - Value comes from the |piece| table above; |piece| > 6 contributes 0.
  - White pieces add their value to the score, black pieces subtract it.
  - Accumulator is 32-bit signed.
- Square address: src_base + 256*board + 4*(8*y + x). Order is x fastest, y outer, squares 0..63.
- Score address: score_base + 4*board.
- State machine:
  - IDLE -> start -> INIT: clear board/square counters and the accumulator; best_idx and best_score take their reset values.
  - INIT -> DONE if num_boards == 0, else RD_SQ.
  - RD_SQ: master_read=1 and address held until master_waitrequest=0, then WT_SQ.
  - WT_SQ: wait for master_readdatavalid; add the square's value. On square 63 go to WR_SCORE, else back to RD_SQ.
  - WR_SCORE: master_write=1, writedata = accumulator, held until master_waitrequest=0, then UPD_BEST.
  - UPD_BEST: replace best if the score is strictly better (side-dependent), so ties keep the lower index. Increment boards_done; go to DONE if it equals num_boards, else clear accumulator and square counter and go to RD_SQ.
  - DONE: wait for the addr-0 read or a new start.
- Only one read outstanding; read and write are never asserted together.
- Latency per board: 64×(issue + data) + 2 cycles minimum with a zero-wait slave.
- rst mid-operation: all strobes drop the next cycle, state returns to IDLE, and no further SDRAM writes occur.

Optional Feature:
BOARD_EVAL_PST_EN
- Defined: pawn advancement bonus.
  - White pawn (+1) at row y adds 10*(y-1).
  - Black pawn (-1) at row y subtracts 10*(6-y).
  - Applied in the same WT_SQ cycle, no extra latency.
- Undefined: pure material only. All other behaviour is identical.

Test Plan:
- Starting board (standard setup, 1 board), side=0 → score word 0, best_idx 0, best_score 0.
- 3 boards: board1 has black queen removed, board2 has white rook removed, side=0 → scores 0, 900, -500; best_idx 1. With side=1 → best_idx 2.
- num_boards=0, start → DONE with no SDRAM traffic; addr-0 read returns 0xFFFFFFFF; addr-5 read returns 0x80000000.
- Two identical boards, each with score 100 → best_idx 0 (tie keeps lower index).
- Random master_waitrequest and 1–5 cycle readdatavalid delay → scores identical to the zero-wait run; address stable while stalled.
- rst asserted at square 30 of board 1 → master_read=0 next cycle, no score write for board 1; a restart produces correct results.
